tile_line_fetcher: RTL and testbench



---
 rtl/tile_pkg.sv | 39 +++
 rtl/tile_line_fetcher_if.sv | 41 ++++
 rtl/tile_line_fetcher.sv | 152 +++++++++++++++
 tb/tb_tile_line_fetcher.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants for the background tile layer: tile geometry, map size,
// the colour-key convention of the tile ROMs, and the fetcher state codes.
package tile_pkg;

  localparam int TILE_W = 20;
  localparam int TILE_H = 20;
  localparam int COLS   = 32;
  localparam int ROWS   = 24;

  // Visible line width and frame height in pixels (640 x 480).
  localparam int LINE_W = TILE_W * COLS;
  localparam int LINE_H = TILE_H * ROWS;

  typedef logic [23:0] color_t;

  localparam color_t KEY_COLOR = 24'h800080;
  localparam color_t BG_COLOR  = 24'h5C94FC;

  // Fetcher state codes, kept as plain constants so older tools and
  // netlist viewers see a stable 3-bit encoding.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_MAP   = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_PIX   = 3'd3;
  localparam state_t ST_FLUSH = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Tile 0 is the empty tile and the key colour marks see-through pixels;
  // both show the sky behind the layer.
  function automatic color_t pixel_color(input logic [3:0] id, input color_t rom);
    if (id == 4'd0 || rom == KEY_COLOR) begin
      return BG_COLOR;
    end
    return rom;
  endfunction

endpackage

// File: rtl/tile_line_fetcher_if.sv
// Bundle of all non-clock signals around the tile line fetcher: the request
// side from frame timing, the tile map / tile ROM read side, and the line
// buffer write side. The fetcher is the master of the bundle; the slave
// modport is the view of the surrounding frame timing, map RAM, ROM mux
// and line buffer.
interface tile_line_fetcher_if;
  import tile_pkg::*;

  logic        line_start;
  logic [8:0]  fetch_y;
  logic        busy;
  logic        done;
  logic        reject;
  logic        overrun;

  logic [9:0]  map_addr;
  logic [3:0]  map_data;
  logic [3:0]  tile_id;
  logic [8:0]  rom_addr;
  color_t      rom_color;

  logic        wr_en;
  logic [9:0]  wr_addr;
  color_t      wr_data;
  logic        wr_bank;

  modport master (
    input  line_start, fetch_y, map_data, rom_color,
    output busy, done, reject, overrun,
    output map_addr, tile_id, rom_addr,
    output wr_en, wr_addr, wr_data, wr_bank
  );

  modport slave (
    output line_start, fetch_y, map_data, rom_color,
    input  busy, done, reject, overrun,
    input  map_addr, tile_id, rom_addr,
    input  wr_en, wr_addr, wr_data, wr_bank
  );

endinterface

// File: rtl/tile_line_fetcher.sv
// Background scanline fetcher. For each accepted request it walks the 32
// tile columns of one tile row: look up the tile id in the map, then read
// the 20 pixels of that tile's current row from the tile ROM mux and write
// them, keyed against the sky colour, into the bank of the ping-pong line
// buffer that the pixel path is not reading. The bank flips once the whole
// line has been written.
module tile_line_fetcher
  import tile_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  tile_line_fetcher_if.master bus
);

  state_t      state;
  logic [4:0]  tile_row;
  logic [4:0]  y_in_tile;
  logic [4:0]  col;
  logic [4:0]  x_in_tile;
  logic [3:0]  tile_id;

  logic        wr_en;
  logic [9:0]  wr_addr;
  color_t      wr_data;
  logic        wr_bank;
  logic        reject;
  logic        overrun;

  logic        req_ok;
  logic        last_x;
  logic        last_col;
  logic [9:0]  pix_x;
  logic [8:0]  rom_addr;
  logic [9:0]  map_addr;

  assign req_ok   = bus.fetch_y < 9'(LINE_H);
  assign last_x   = x_in_tile == 5'(TILE_W - 1);
  assign last_col = col == 5'(COLS - 1);

  // Screen x of the pixel currently being read from the ROM.
  assign pix_x = 10'(col) * 10'(TILE_W) + 10'(x_in_tile);

  // The map RAM has a registered read, so the address only needs to be
  // valid in MAP; elsewhere it is parked at 0.
  assign map_addr = (state == ST_MAP)
                  ? 10'(tile_row) * 10'(COLS) + 10'(col)
                  : 10'd0;

  // The ROM mux is combinational, so the address is live only while
  // pixels are being read.
  assign rom_addr = (state == ST_PIX)
                  ? 9'(y_in_tile) * 9'(TILE_W) + 9'(x_in_tile)
                  : 9'd0;

  // Sequencer: accept a line, then MAP/WAIT/PIXx20 per column, then
  // FLUSH for the last write and DONE to hand the bank over.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      tile_row  <= 5'd0;
      y_in_tile <= 5'd0;
      col       <= 5'd0;
      x_in_tile <= 5'd0;
      tile_id   <= 4'd0;
      wr_bank   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.line_start && req_ok) begin
            tile_row  <= 5'(bus.fetch_y / 9'(TILE_H));
            y_in_tile <= 5'(bus.fetch_y % 9'(TILE_H));
            col       <= 5'd0;
            x_in_tile <= 5'd0;
            state     <= ST_MAP;
          end
        end
        ST_MAP: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          tile_id   <= bus.map_data;
          x_in_tile <= 5'd0;
          state     <= ST_PIX;
        end
        ST_PIX: begin
          if (last_x) begin
            x_in_tile <= 5'd0;
            if (last_col) begin
              state <= ST_FLUSH;
            end else begin
              col   <= col + 5'd1;
              state <= ST_MAP;
            end
          end else begin
            x_in_tile <= x_in_tile + 5'd1;
          end
        end
        ST_FLUSH: begin
          state <= ST_DONE;
        end
        ST_DONE: begin
          wr_bank <= ~wr_bank;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered line buffer write: the ROM colour read during a PIX cycle
  // is keyed and written one cycle later, so the last pixel lands in FLUSH.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_en   <= 1'b0;
      wr_addr <= 10'd0;
      wr_data <= '0;
    end else begin
      wr_en <= (state == ST_PIX);
      if (state == ST_PIX) begin
        wr_addr <= pix_x;
        wr_data <= pixel_color(tile_id, bus.rom_color);
      end
    end
  end

  // One-cycle status pulses for requests that cannot be served: a line
  // outside the frame, or a request while a fetch is still running.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      reject  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      reject  <= (state == ST_IDLE) && bus.line_start && !req_ok;
      overrun <= (state != ST_IDLE) && bus.line_start;
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.reject   = reject;
  assign bus.overrun  = overrun;
  assign bus.map_addr = map_addr;
  assign bus.tile_id  = tile_id;
  assign bus.rom_addr = rom_addr;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  assign bus.wr_bank  = wr_bank;

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Testbench for tile_line_fetcher: a map RAM and tile ROM model around the
// fetcher, a table of single-request vectors, and whole-line runs checked
// against a pixel-level model of what the line buffer should receive.
module tb_tile_line_fetcher;
  import tile_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  tile_line_fetcher_if bus_if();

  tile_line_fetcher dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus_if)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic exp_bank = 1'b0;

  logic [3:0] map_mem [0:1023];

  typedef struct {
    int     cycle;
    int     addr;
    color_t data;
    logic   bank;
  } wr_rec_t;

  typedef struct {
    int         y;
    logic       exp_reject;
    logic       exp_busy;
    logic [9:0] exp_map;
    logic [8:0] exp_rom;
  } req_vec_t;

  // Tile map RAM with a one-cycle registered read
  always @(posedge clk) bus_if.map_data <= map_mem[bus_if.map_addr];

  // Tile ROM contents: a mix of key-coloured, fixed and address-derived
  // colours; tile 0 returns junk that must never reach the line buffer.
  function automatic color_t rom_fn(input logic [3:0] id, input logic [8:0] addr);
    int a;
    a = int'(addr);
    if (id == 4'd0) return 24'hC0FFEE ^ {15'd0, addr};
    if ((a + 3 * int'(id)) % 11 == 0) return KEY_COLOR;
    if (a % 17 == 5) return 24'hB24204;
    return {id, 20'(a * 97 + int'(id) * 1234)};
  endfunction

  always_comb bus_if.rom_color = rom_fn(bus_if.tile_id, bus_if.rom_addr);

  // What screen pixel x of line y should look like
  function automatic color_t exp_pixel(input int y, input int x);
    int     id;
    color_t rc;
    id = int'(map_mem[(y / TILE_H) * COLS + x / TILE_W]);
    rc = rom_fn(4'(id), 9'((y % TILE_H) * TILE_W + x % TILE_W));
    if (id == 0 || rc == KEY_COLOR) return BG_COLOR;
    return rc;
  endfunction

  function automatic int exp_wr_cycle(input int x);
    return (x / 20) * 22 + x % 20 + 4;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.line_start = 1'b0;
    bus_if.fetch_y = 9'd0;
    tick();
    reset = 1'b0;
    tick();
    exp_bank = 1'b0;
  endtask

  task automatic randomize_map();
    for (int i = 0; i < 1024; i++) map_mem[i] = 4'($urandom_range(0, 15));
  endtask

  // Single request presented in the current cycle; observe cycles 1 and 3
  task automatic apply_stimulus(input req_vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d_y%0d", idx, v.y);
    bus_if.fetch_y = 9'(v.y);
    bus_if.line_start = 1'b1;
    tick();
    bus_if.line_start = 1'b0;
    check_output({tag, "_reject_c1"}, 32'(bus_if.reject), 32'(v.exp_reject));
    check_output({tag, "_busy_c1"}, 32'(bus_if.busy), 32'(v.exp_busy));
    check_output({tag, "_map_addr_c1"}, 32'(bus_if.map_addr), 32'(v.exp_map));
    tick();
    tick();
    check_output({tag, "_reject_c3"}, 32'(bus_if.reject), 32'd0);
    check_output({tag, "_rom_addr_c3"}, 32'(bus_if.rom_addr), 32'(v.exp_rom));
  endtask

  // Full line fetch starting in the current cycle. inject>0 pulses a stray
  // request in that cycle; reset_at>0 asserts reset in that cycle.
  // Returns in cycle 707 with the request inputs idle.
  task automatic run_line(input string tag, input int y, input int inject, input int reset_at);
    wr_rec_t wq[$];
    wr_rec_t r;
    int busy_bad, done_cnt, done_cyc, ov_cnt, ov_cyc, rej_cnt;
    int map_bad, rom_bad, c, ph, exp_writes, bad_idx, last_busy, ecyc;
    logic line_bank;
    logic exp_busy;
    color_t ed;
    busy_bad = 0; done_cnt = 0; done_cyc = -1; ov_cnt = 0; ov_cyc = -1;
    rej_cnt = 0; map_bad = 0; rom_bad = 0; bad_idx = -1;
    last_busy = (reset_at > 0) ? reset_at : 706;
    line_bank = exp_bank;

    bus_if.fetch_y = 9'(y);
    bus_if.line_start = 1'b1;
    tick();
    bus_if.line_start = 1'b0;

    for (int k = 1; k <= 706; k++) begin
      exp_busy = (k <= last_busy);
      if (bus_if.busy !== exp_busy) busy_bad++;
      if (bus_if.done) begin done_cnt++; done_cyc = k; end
      if (bus_if.overrun) begin ov_cnt++; ov_cyc = k; end
      if (bus_if.reject) rej_cnt++;
      if (bus_if.wr_en) begin
        r.cycle = k;
        r.addr = int'(bus_if.wr_addr);
        r.data = bus_if.wr_data;
        r.bank = bus_if.wr_bank;
        wq.push_back(r);
      end
      if (k <= 704 && (reset_at == 0 || k <= reset_at)) begin
        c = (k - 1) / 22;
        ph = (k - 1) % 22;
        if (ph == 0 && bus_if.map_addr !== 10'((y / 20) * 32 + c)) map_bad++;
        if (ph >= 2 && bus_if.rom_addr !== 9'((y % 20) * 20 + ph - 2)) rom_bad++;
      end
      if (reset_at > 0 && k == reset_at + 1) begin
        check_output({tag, "_wr_en_after_reset"}, 32'(bus_if.wr_en), 32'd0);
        check_output({tag, "_busy_after_reset"}, 32'(bus_if.busy), 32'd0);
        check_output({tag, "_bank_after_reset"}, 32'(bus_if.wr_bank), 32'd0);
      end
      bus_if.line_start = (k == inject);
      if (k == inject) bus_if.fetch_y = 9'($urandom_range(0, 479));
      reset = (k == reset_at);
      tick();
    end
    bus_if.line_start = 1'b0;
    reset = 1'b0;

    if (reset_at == 0) begin
      exp_writes = 640;
      exp_bank = ~exp_bank;
    end else begin
      exp_writes = 0;
      for (int x = 0; x < 640; x++) if (exp_wr_cycle(x) <= reset_at) exp_writes++;
      exp_bank = 1'b0;
    end

    check_output({tag, "_write_count"}, 32'(wq.size()), 32'(exp_writes));
    foreach (wq[i]) begin
      if (bad_idx < 0) begin
        ed = exp_pixel(y, i);
        ecyc = exp_wr_cycle(i);
        if (wq[i].addr != i || wq[i].data !== ed || wq[i].cycle != ecyc ||
            wq[i].bank !== line_bank) bad_idx = i;
      end
    end
    checks++;
    if (bad_idx >= 0) begin
      errors++;
      $display("[TB] FAIL %s_write_stream: write %0d got addr=%0d data=%06h cycle=%0d bank=%0b, expected addr=%0d data=%06h cycle=%0d bank=%0b",
               tag, bad_idx, wq[bad_idx].addr, wq[bad_idx].data, wq[bad_idx].cycle,
               wq[bad_idx].bank, bad_idx, exp_pixel(y, bad_idx), exp_wr_cycle(bad_idx), line_bank);
    end

    check_output({tag, "_busy_bad_cycles"}, 32'(busy_bad), 32'd0);
    check_output({tag, "_map_addr_bad"}, 32'(map_bad), 32'd0);
    check_output({tag, "_rom_addr_bad"}, 32'(rom_bad), 32'd0);
    check_output({tag, "_reject_count"}, 32'(rej_cnt), 32'd0);
    if (reset_at == 0) begin
      check_output({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      check_output({tag, "_done_cycle"}, 32'(done_cyc), 32'd706);
    end else begin
      check_output({tag, "_done_count"}, 32'(done_cnt), 32'd0);
    end
    if (inject > 0) begin
      check_output({tag, "_overrun_count"}, 32'(ov_cnt), 32'd1);
      check_output({tag, "_overrun_cycle"}, 32'(ov_cyc), 32'(inject + 1));
    end else begin
      check_output({tag, "_overrun_count"}, 32'(ov_cnt), 32'd0);
    end

    // Cycle 707: idle again, bank handed over
    check_output({tag, "_busy_c707"}, 32'(bus_if.busy), 32'd0);
    check_output({tag, "_done_c707"}, 32'(bus_if.done), 32'd0);
    check_output({tag, "_wr_en_c707"}, 32'(bus_if.wr_en), 32'd0);
    check_output({tag, "_bank_c707"}, 32'(bus_if.wr_bank), 32'(exp_bank));
  endtask

  req_vec_t vecs [8];

  initial begin
    int rej_seen, busy_seen, wr_seen, y, inj;

    bus_if.line_start = 1'b0;
    bus_if.fetch_y = 9'd0;
    for (int i = 0; i < 1024; i++) map_mem[i] = 4'd0;

    vecs[0] = '{0,   1'b0, 1'b1, 10'd0,   9'd0};
    vecs[1] = '{19,  1'b0, 1'b1, 10'd0,   9'd380};
    vecs[2] = '{20,  1'b0, 1'b1, 10'd32,  9'd0};
    vecs[3] = '{45,  1'b0, 1'b1, 10'd64,  9'd100};
    vecs[4] = '{250, 1'b0, 1'b1, 10'd384, 9'd200};
    vecs[5] = '{479, 1'b0, 1'b1, 10'd736, 9'd380};
    vecs[6] = '{480, 1'b1, 1'b0, 10'd0,   9'd0};
    vecs[7] = '{511, 1'b1, 1'b0, 10'd0,   9'd0};

    // Reset state, observed while reset is held
    reset = 1'b1;
    tick();
    tick();
    check_output("rst_busy", 32'(bus_if.busy), 32'd0);
    check_output("rst_done", 32'(bus_if.done), 32'd0);
    check_output("rst_reject", 32'(bus_if.reject), 32'd0);
    check_output("rst_overrun", 32'(bus_if.overrun), 32'd0);
    check_output("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
    check_output("rst_wr_bank", 32'(bus_if.wr_bank), 32'd0);
    check_output("rst_wr_addr", 32'(bus_if.wr_addr), 32'd0);
    check_output("rst_wr_data", 32'(bus_if.wr_data), 32'd0);
    check_output("rst_map_addr", 32'(bus_if.map_addr), 32'd0);
    check_output("rst_rom_addr", 32'(bus_if.rom_addr), 32'd0);
    check_output("rst_tile_id", 32'(bus_if.tile_id), 32'd0);
    reset = 1'b0;
    tick();

    // Reset takes priority over a same-cycle request
    reset = 1'b1;
    bus_if.fetch_y = 9'd10;
    bus_if.line_start = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.line_start = 1'b0;
    check_output("rst_vs_start_busy", 32'(bus_if.busy), 32'd0);
    tick();

    // Table of single requests: acceptance, row/line arithmetic, rejection
    for (int i = 0; i < 8; i++) begin
      do_reset();
      apply_stimulus(vecs[i], i);
    end

    // Reject held over several cycles: one pulse, no activity
    do_reset();
    bus_if.fetch_y = 9'd480;
    bus_if.line_start = 1'b1;
    tick();
    bus_if.line_start = 1'b0;
    rej_seen = 0; busy_seen = 0; wr_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus_if.reject) rej_seen++;
      if (bus_if.busy) busy_seen++;
      if (bus_if.wr_en) wr_seen++;
      tick();
    end
    check_output("reject_pulses", 32'(rej_seen), 32'd1);
    check_output("reject_busy", 32'(busy_seen), 32'd0);
    check_output("reject_writes", 32'(wr_seen), 32'd0);

    // Empty line, then the address-arithmetic line chained at cycle 707
    do_reset();
    for (int i = 0; i < 1024; i++) map_mem[i] = 4'd0;
    run_line("empty", 0, 0, 0);
    map_mem[67] = 4'd1;
    run_line("addr45", 45, 0, 0);

    // Stray request mid-fetch
    randomize_map();
    run_line("overrun", 333, 100, 0);

    // Abort at cycle 300, then a normal line from bank 0
    run_line("reset_mid", 123, 0, 300);
    run_line("after_reset", 0, 0, 0);

    // Randomised lines over random maps
    for (int n = 0; n < 4; n++) begin
      randomize_map();
      y = int'($urandom_range(0, 479));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 704)) : 0;
      run_line($sformatf("rand%0d_y%0d", n, y), y, inj, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
